// File: rtl/fetch_pipe.sv
// Instruction-fetch stage: PC register, memory handshake, redirect/stall handling,
// IF/ID pipeline register, sticky misaligned-target flag and saturating fetch counter.
module fetch_pipe #(
    parameter int unsigned   N        = 64,
    parameter int unsigned   IW       = 32,
    parameter int unsigned   INC      = 4,
    parameter logic [N-1:0]  RESET_PC = '0,
    parameter int unsigned   CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PCSrc_F,
    input  logic [N-1:0]     PCBranch_F,
    input  logic             stall_F,
    input  logic             imem_ready,
    input  logic [IW-1:0]    imem_data_F,
    output logic [N-1:0]     imem_addr_F,
    output logic [IW-1:0]    instr_D,
    output logic [N-1:0]     pc_D,
    output logic             valid_D,
    output logic             misalign_F,
    output logic [CNT_W-1:0] fetch_count
);

    // Low address bits that must be zero for an INC-aligned PC (empty when INC=1).
    localparam logic [N-1:0] LOW_MASK = N'(INC - 1);

    logic [N-1:0] pc;
    logic         target_misaligned;

    assign imem_addr_F       = pc;
    assign target_misaligned = |(PCBranch_F & LOW_MASK);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            instr_D     <= '0;
            pc_D        <= '0;
            valid_D     <= 1'b0;
            misalign_F  <= 1'b0;
            fetch_count <= '0;
        end else if (PCSrc_F) begin
            // Redirect beats stall: the in-flight slot is flushed, not held.
            pc      <= PCBranch_F & ~LOW_MASK;
            valid_D <= 1'b0;
            if (target_misaligned) begin
                misalign_F <= 1'b1;
            end
        end else if (!stall_F) begin
            if (imem_ready) begin
                instr_D <= imem_data_F;
                pc_D    <= pc;
                valid_D <= 1'b1;
                pc      <= pc + N'(INC);
                if (fetch_count != '1) begin
                    fetch_count <= fetch_count + CNT_W'(1);
                end
            end else begin
                valid_D <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pipe.sv
// Bench for fetch_pipe: two instances (default 64-bit, and 8-bit PC with 2-bit counter)
// checked every cycle against a transaction-level model, plus directed literal checks.
module tb_fetch_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pcsrc = 1'b0;
    logic [63:0] branch = '0;
    logic        stall = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] data = '0;

    logic [63:0] a_addr, a_pcd;
    logic [31:0] a_instr;
    logic        a_valid, a_mis;
    logic [31:0] a_cnt;

    logic [7:0]  b_addr, b_pcd;
    logic [31:0] b_instr;
    logic        b_valid, b_mis;
    logic [1:0]  b_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_pipe dut_a (
        .clk(clk), .reset(reset), .PCSrc_F(pcsrc), .PCBranch_F(branch),
        .stall_F(stall), .imem_ready(ready), .imem_data_F(data),
        .imem_addr_F(a_addr), .instr_D(a_instr), .pc_D(a_pcd), .valid_D(a_valid),
        .misalign_F(a_mis), .fetch_count(a_cnt)
    );

    fetch_pipe #(.N(8), .IW(32), .INC(4), .RESET_PC(8'hF0), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .PCSrc_F(pcsrc), .PCBranch_F(branch[7:0]),
        .stall_F(stall), .imem_ready(ready), .imem_data_F(data),
        .imem_addr_F(b_addr), .instr_D(b_instr), .pc_D(b_pcd), .valid_D(b_valid),
        .misalign_F(b_mis), .fetch_count(b_cnt)
    );

    typedef struct {
        logic [63:0] pc;
        logic [63:0] instr;
        logic [63:0] pcd;
        logic        valid;
        logic        mis;
        logic [63:0] cnt;
    } mstate_t;

    mstate_t ma, mb;
    logic    model_live = 1'b0;

    // One clock edge of the stage, from the priority rules: reset, redirect, stall, wait, fire.
    function automatic mstate_t model_step(input mstate_t s, input logic [63:0] pc_mask,
                                           input logic [63:0] cap, input logic [63:0] rpc);
        mstate_t n = s;
        if (reset) begin
            n.pc = rpc; n.instr = 0; n.pcd = 0; n.valid = 0; n.mis = 0; n.cnt = 0;
        end else if (pcsrc) begin
            n.pc    = (branch & pc_mask) - ((branch & pc_mask) % 4);
            n.valid = 0;
            if ((branch % 4) != 0) n.mis = 1;
        end else if (stall) begin
            n = s;
        end else if (!ready) begin
            n.valid = 0;
        end else begin
            n.instr = {32'h0, data};
            n.pcd   = s.pc;
            n.valid = 1;
            n.pc    = (s.pc + 4) & pc_mask;
            if (s.cnt < cap) n.cnt = s.cnt + 1;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        ma <= model_step(ma, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF, 64'h0);
        mb <= model_step(mb, 64'hFF, 64'd3, 64'hF0);
        if (reset) model_live <= 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_live) begin
            chk("a_addr",  a_addr,           ma.pc);
            chk("a_instr", {32'h0, a_instr}, ma.instr);
            chk("a_pcd",   a_pcd,            ma.pcd);
            chk("a_valid", {63'h0, a_valid}, {63'h0, ma.valid});
            chk("a_mis",   {63'h0, a_mis},   {63'h0, ma.mis});
            chk("a_cnt",   {32'h0, a_cnt},   ma.cnt);
            chk("b_addr",  {56'h0, b_addr},  mb.pc);
            chk("b_instr", {32'h0, b_instr}, mb.instr);
            chk("b_pcd",   {56'h0, b_pcd},   mb.pcd);
            chk("b_valid", {63'h0, b_valid}, {63'h0, mb.valid});
            chk("b_mis",   {63'h0, b_mis},   {63'h0, mb.mis});
            chk("b_cnt",   {62'h0, b_cnt},   mb.cnt);
        end
    end

    task automatic step(input logic r, input logic ps, input logic st, input logic rdy,
                        input logic [63:0] br, input logic [31:0] d);
        @(negedge clk);
        reset = r; pcsrc = ps; stall = st; ready = rdy; branch = br; data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        chk("lit_reset_addr",  a_addr, 64'h0);
        chk("lit_reset_valid", {63'h0, a_valid}, 64'h0);
        chk("lit_reset_b_addr", {56'h0, b_addr}, 64'hF0);

        step(0, 0, 0, 1, 0, 32'hA0);
        chk("lit_f1_pcd", a_pcd, 64'h0);
        chk("lit_f1_instr", {32'h0, a_instr}, 64'hA0);
        chk("lit_f1_addr", a_addr, 64'h4);
        step(0, 0, 0, 1, 0, 32'hA1);
        chk("lit_f2_pcd", a_pcd, 64'h4);
        step(0, 0, 0, 1, 0, 32'hA2);
        chk("lit_f3_addr", a_addr, 64'hC);
        chk("lit_f3_cnt", {32'h0, a_cnt}, 64'd3);

        step(0, 1, 0, 1, 64'h100, 32'hEE);
        chk("lit_redir_addr", a_addr, 64'h100);
        chk("lit_redir_valid", {63'h0, a_valid}, 64'h0);
        chk("lit_redir_cnt", {32'h0, a_cnt}, 64'd3);
        step(0, 0, 0, 1, 0, 32'hB0);
        chk("lit_after_redir_pcd", a_pcd, 64'h100);

        step(0, 0, 1, 1, 0, 32'hEE);
        step(0, 0, 1, 0, 0, 32'hEE);
        chk("lit_stall_addr", a_addr, 64'h104);
        chk("lit_stall_valid", {63'h0, a_valid}, 64'h1);
        chk("lit_stall_cnt", {32'h0, a_cnt}, 64'd4);
        step(0, 0, 0, 0, 0, 32'hEE);
        chk("lit_wait_addr", a_addr, 64'h104);
        chk("lit_wait_valid", {63'h0, a_valid}, 64'h0);
        step(0, 0, 0, 1, 0, 32'hB1);
        chk("lit_resume_addr", a_addr, 64'h108);

        step(0, 1, 1, 1, 64'h206, 32'hEE);
        chk("lit_mis_addr", a_addr, 64'h204);
        chk("lit_mis_flag", {63'h0, a_mis}, 64'h1);
        chk("lit_mis_valid", {63'h0, a_valid}, 64'h0);
        step(0, 0, 0, 1, 0, 32'hC0);
        step(0, 0, 0, 1, 0, 32'hC1);
        chk("lit_mis_sticky", {63'h0, a_mis}, 64'h1);
        chk("lit_mis_pcd", a_pcd, 64'h208);

        step(0, 1, 0, 1, 64'h300, 32'hEE);
        step(0, 1, 0, 1, 64'h400, 32'hEE);
        chk("lit_b2b_addr", a_addr, 64'h400);
        chk("lit_b2b_valid", {63'h0, a_valid}, 64'h0);

        step(1, 1, 1, 1, 64'h500, 32'hEE);
        chk("lit_midrst_addr", a_addr, 64'h0);
        chk("lit_midrst_mis", {63'h0, a_mis}, 64'h0);
        chk("lit_midrst_cnt", {32'h0, a_cnt}, 64'h0);

        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 1, 0, 32'hD0 + 32'(i));
            if (i == 3) begin
                chk("lit_wrap_addr", {56'h0, b_addr}, 64'h00);
                chk("lit_wrap_pcd", {56'h0, b_pcd}, 64'hFC);
            end
        end
        chk("lit_sat_cnt", {62'h0, b_cnt}, 64'd3);
        chk("lit_a_cnt5", {32'h0, a_cnt}, 64'd5);

        @(negedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
